barrier_sequencer: RTL and testbench

Game-flow controller that drives the three barrier sprite lanes (left, mid, right). It runs on the pixel clock and advances on frame ticks derived from `i_v_sync`. It picks a lane pseudo-randomly and asserts that lane's barrier `active` for a fixed number of frames. It consumes the barriers' `in_position` flags together with the player lane to judge each barrier as a collision or a dodge, and maintains score, lives and game-over.

---
 rtl/barrier_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_barrier_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/barrier_sequencer.sv
// Barrier lane sequencer: spawns one barrier at a time on frame ticks, judges hit/dodge, tracks score/lives.
// Optional: define BARRIER_SEQ_INVINCIBLE_EN to keep collision pulses but never lose lives.
module barrier_sequencer #(
  parameter int          SPAWN_GAP     = 30,
  parameter int          TRAVEL_FRAMES = 40,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_v_sync,
  input  logic        i_game_en,
  input  logic [1:0]  i_player_lane,
  input  logic [2:0]  i_in_position,
  output logic [2:0]  o_active,
  output logic [1:0]  o_lane,
  output logic        o_collision,
  output logic        o_dodge,
  output logic [15:0] o_score,
  output logic [1:0]  o_lives,
  output logic        o_game_over
);

  localparam int CNT_MAX = (SPAWN_GAP > TRAVEL_FRAMES) ? SPAWN_GAP : TRAVEL_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SPAWN_GAP - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(TRAVEL_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, GAP, RUN, RETIRE, OVER} state_t;

  state_t        state_reg, state_next;
  logic          vs_q;
  logic [2:0]    ip_q;
  logic [15:0]   lfsr_reg, lfsr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          judged_reg, judged_next;
  logic [2:0]    active_reg, active_next;
  logic [1:0]    lane_reg, lane_next;
  logic          coll_reg, coll_next;
  logic          dodge_reg, dodge_next;
  logic [15:0]   score_reg, score_next;
  logic [1:0]    lives_reg, lives_next;
  logic          over_reg, over_next;

  logic          tick;
  logic [2:0]    rise;
  logic          judge_edge;
  logic [15:0]   lfsr_step;
  logic [1:0]    spawn_lane;

  assign tick = i_v_sync & ~vs_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rise
      assign rise[gi] = i_in_position[gi] & ~ip_q[gi];
    end
  endgenerate

  // Only the lane currently carrying a barrier can be judged, once per barrier.
  assign judge_edge = rise[lane_reg] & ~judged_reg;
  assign lfsr_step  = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
  assign spawn_lane = (lfsr_step[1:0] == 2'd3) ? 2'd1 : lfsr_step[1:0];

  always_comb begin
    state_next  = state_reg;
    lfsr_next   = lfsr_reg;
    cnt_next    = cnt_reg;
    judged_next = judged_reg;
    active_next = active_reg;
    lane_next   = lane_reg;
    coll_next   = 1'b0;
    dodge_next  = 1'b0;
    score_next  = score_reg;
    lives_next  = lives_reg;
    over_next   = over_reg;

    if (!i_game_en) begin
      state_next  = IDLE;
      active_next = 3'b000;
    end else begin
      case (state_reg)
        IDLE: begin
          active_next = 3'b000;
          score_next  = 16'd0;
          lives_next  = 2'd3;
          over_next   = 1'b0;
          cnt_next    = '0;
          state_next  = GAP;
        end
        GAP: begin
          active_next = 3'b000;
          if (tick) begin
            if (cnt_reg == GAP_LAST) begin
              lfsr_next   = lfsr_step;
              lane_next   = spawn_lane;
              active_next = 3'b001 << spawn_lane;
              cnt_next    = '0;
              judged_next = 1'b0;
              state_next  = RUN;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (cnt_reg == RUN_LAST) begin
              active_next = 3'b000;
              cnt_next    = '0;
              state_next  = RETIRE;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          // Judgement overrides the tick's target state when the last life is lost.
          if (judge_edge) begin
            judged_next = 1'b1;
            if (i_player_lane == lane_reg) begin
              coll_next = 1'b1;
`ifndef BARRIER_SEQ_INVINCIBLE_EN
              lives_next = lives_reg - 2'd1;
              if (lives_reg == 2'd1) begin
                state_next  = OVER;
                active_next = 3'b000;
                over_next   = 1'b1;
              end
`endif
            end else begin
              dodge_next = 1'b1;
              if (score_reg != 16'hFFFF) score_next = score_reg + 16'd1;
            end
          end
        end
        RETIRE: begin
          active_next = 3'b000;
          if (tick) begin
            cnt_next   = '0;
            state_next = GAP;
          end
        end
        OVER: begin
          active_next = 3'b000;
          over_next   = 1'b1;
        end
        default: begin
          active_next = 3'b000;
          state_next  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      vs_q       <= 1'b0;
      ip_q       <= 3'b000;
      lfsr_reg   <= LFSR_SEED;
      cnt_reg    <= '0;
      judged_reg <= 1'b0;
      active_reg <= 3'b000;
      lane_reg   <= 2'd0;
      coll_reg   <= 1'b0;
      dodge_reg  <= 1'b0;
      score_reg  <= 16'd0;
      lives_reg  <= 2'd3;
      over_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      vs_q       <= i_v_sync;
      ip_q       <= i_in_position;
      lfsr_reg   <= lfsr_next;
      cnt_reg    <= cnt_next;
      judged_reg <= judged_next;
      active_reg <= active_next;
      lane_reg   <= lane_next;
      coll_reg   <= coll_next;
      dodge_reg  <= dodge_next;
      score_reg  <= score_next;
      lives_reg  <= lives_next;
      over_reg   <= over_next;
    end
  end

  assign o_active    = active_reg;
  assign o_lane      = lane_reg;
  assign o_collision = coll_reg;
  assign o_dodge     = dodge_reg;
  assign o_score     = score_reg;
  assign o_lives     = lives_reg;
  assign o_game_over = over_reg;

endmodule

// File: tb/tb_barrier_sequencer.sv
// Testbench for barrier_sequencer: directed flow with randomized player lanes and edge patterns,
// checked against a counter/LFSR reference model.
module tb_barrier_sequencer;
  localparam int          SG   = 2;
  localparam int          TF   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, v_sync, game_en;
  logic [1:0]  player;
  logic [2:0]  in_pos;
  logic [2:0]  active;
  logic [1:0]  lane;
  logic        coll, dodge;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        over;

  always #5 clk = ~clk;

  barrier_sequencer #(.SPAWN_GAP(SG), .TRAVEL_FRAMES(TF), .LFSR_SEED(SEED)) dut (
    .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_game_en(game_en),
    .i_player_lane(player), .i_in_position(in_pos),
    .o_active(active), .o_lane(lane), .o_collision(coll), .o_dodge(dodge),
    .o_score(score), .o_lives(lives), .o_game_over(over)
  );

  int tests = 0;
  int fails = 0;
  int coll_cnt = 0;
  int dodge_cnt = 0;

  // Pulse counters: a pulse longer than one cycle inflates the count.
  always @(negedge clk) begin
    if (coll === 1'b1) coll_cnt++;
    if (dodge === 1'b1) dodge_cnt++;
  end

  logic [15:0] m_lfsr;
  int          m_lane, m_score, m_lives, m_coll, m_dodge;
  bit          m_over;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int lane_of(input logic [15:0] x);
    int l;
    l = int'(x & 16'h3);
    return (l == 3) ? 1 : l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    v_sync = 1'b1; step();
    v_sync = 1'b0; step();
  endtask

  task automatic judge(input logic [1:0] pl);
    if (int'(pl) == m_lane) begin
      m_coll++;
`ifndef BARRIER_SEQ_INVINCIBLE_EN
      if (m_lives > 0) begin
        m_lives--;
        if (m_lives == 0) m_over = 1'b1;
      end
`endif
    end else begin
      m_dodge++;
      if (m_score < 65535) m_score++;
    end
  endtask

  task automatic spawn();
    for (int i = 0; i < SG - 1; i++) tick();
    chk("gap_active", 32'(active), 32'd0);
    v_sync = 1'b1; step();
    m_lfsr = lfsr_adv(m_lfsr);
    m_lane = lane_of(m_lfsr);
    chk("spawn_lane", 32'(lane), 32'(m_lane));
    chk("spawn_active", 32'(active), 32'(1 << m_lane));
    v_sync = 1'b0; step();
  endtask

  // mode 0: no edges, 1: edge on selected lane (held, retoggled), 2: edges on other lanes only,
  // 3: selected-lane edge in the same cycle as the terminating tick
  task automatic barrier(input bit hit, input int mode);
    logic [2:0] onehot;
    logic [1:0] pl;
    spawn();
    onehot = 3'(1 << m_lane);
    pl = hit ? 2'(m_lane) : 2'((m_lane + 1 + int'($urandom_range(0, 2))) % 4);
    player = pl;
    if (mode == 1) begin
      in_pos = onehot;
      repeat ($urandom_range(5, 100)) step();
      in_pos = 3'b000; step();
      in_pos = onehot; step(); step();
      in_pos = 3'b000; step();
      judge(pl);
      chk("judge_coll_cnt", 32'(coll_cnt), 32'(m_coll));
      chk("judge_dodge_cnt", 32'(dodge_cnt), 32'(m_dodge));
    end else if (mode == 2) begin
      repeat (6) begin
        in_pos = 3'($urandom) & ~onehot;
        step();
      end
      in_pos = 3'b000; step();
    end
    for (int i = 0; i < TF - 1; i++) begin
      tick();
      chk("travel_active", 32'(active), m_over ? 32'd0 : 32'(onehot));
    end
    v_sync = 1'b1;
    if (mode == 3) in_pos = onehot;
    step();
    chk("retire_active", 32'(active), 32'd0);
    if (mode == 3) begin
      judge(pl);
      chk("same_edge_pulse", 32'(coll | dodge), 32'd1);
    end
    v_sync = 1'b0; in_pos = 3'b000; step();
    chk("coll_cnt", 32'(coll_cnt), 32'(m_coll));
    chk("dodge_cnt", 32'(dodge_cnt), 32'(m_dodge));
    chk("score", 32'(score), 32'(m_score));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("game_over", 32'(over), 32'(m_over));
    $display("[TB] barrier lane=%0d player=%0d mode=%0d score=%0d lives=%0d over=%0d",
             m_lane, pl, mode, score, lives, over);
    tick();
  endtask

  initial begin
    rst = 1'b1; game_en = 1'b0; v_sync = 1'b0; in_pos = 3'b000; player = 2'd3;
    step(); step();
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_lane", 32'(lane), 32'd0);
    chk("rst_coll", 32'(coll), 32'd0);
    chk("rst_dodge", 32'(dodge), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_over", 32'(over), 32'd0);

    m_lfsr = SEED; m_lane = 0; m_score = 0; m_lives = 3; m_over = 1'b0; m_coll = 0; m_dodge = 0;
    rst = 1'b0; game_en = 1'b1;
    step();

    barrier(1'b0, 1);
    barrier(1'b0, 2);
    barrier(1'b0, 3);
    barrier(1'b0, 0);
    repeat (3) barrier(1'b0, int'($urandom_range(1, 3)));

    // Disable mid-RUN, then re-enable
    spawn();
    step(); step();
    game_en = 1'b0; step();
    chk("dis_active", 32'(active), 32'd0);
    chk("dis_score", 32'(score), 32'(m_score));
    chk("dis_lives", 32'(lives), 32'(m_lives));
    tick(); tick();
    chk("dis_active_ticks", 32'(active), 32'd0);
    game_en = 1'b1; step();
    m_score = 0; m_lives = 3; m_over = 1'b0;
    chk("reen_score", 32'(score), 32'd0);
    chk("reen_lives", 32'(lives), 32'd3);
    chk("reen_over", 32'(over), 32'd0);
    $display("[TB] re-enable score=%0d lives=%0d", score, lives);

    repeat (3) barrier(1'b1, 1);
    repeat (4) tick();
`ifndef BARRIER_SEQ_INVINCIBLE_EN
    chk("over_active", 32'(active), 32'd0);
    chk("over_flag", 32'(over), 32'd1);
    chk("over_lives", 32'(lives), 32'd0);
`else
    chk("inv_lives", 32'(lives), 32'd3);
    chk("inv_over", 32'(over), 32'd0);
`endif
    $display("[TB] after hits lives=%0d over=%0d active=%0b", lives, over, active);

    // Reset mid-RUN discards the in-flight judgement
    game_en = 1'b0; step();
    game_en = 1'b1; step();
    spawn();
    player = 2'(m_lane);
    in_pos = 3'(1 << m_lane);
    rst = 1'b1; step();
    rst = 1'b0; in_pos = 3'b000;
    chk("mrst_active", 32'(active), 32'd0);
    chk("mrst_lane", 32'(lane), 32'd0);
    chk("mrst_lives", 32'(lives), 32'd3);
    chk("mrst_score", 32'(score), 32'd0);
    step(); step();
    chk("mrst_coll_cnt", 32'(coll_cnt), 32'(m_coll));
    chk("mrst_dodge_cnt", 32'(dodge_cnt), 32'(m_dodge));
    m_lfsr = SEED; m_score = 0; m_lives = 3; m_over = 1'b0;
    spawn();
    $display("[TB] post-reset spawn lane=%0d active=%0b", lane, active);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
